seven_seg_scanner: RTL and testbench
====================================

// Module: seven_seg_scanner
// PURPOSE
//  Consumer of the clock's packed BCD display word {H10,H1,M10,M1}: time-multiplexes four
//  digits onto a common-anode 4-digit 7-segment display. Adds per-digit blink (time/alarm
//  adjust), hour leading-zero blanking and per-digit decimal point (colon). Sits between the
//  time/alarm counters and the board pins.
// PARAMETERS
//  REFRESH_DIV  100000  clk cycles each digit slot is active (>=2)
//  BLINK_DIV    25000000 clk cycles per blink half-period (>=2)
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  rst        in   1   asynchronous, active-high reset
//  digits     in   16  BCD: [3:0]=M1, [7:4]=M10, [11:8]=H1, [15:12]=H10
//  blink_en   in   4   bit i=1: digit i blinks (off during blink-off phase)
//  lz_blank   in   1   1: blank digit 3 when its value is 0
//  dp_mask    in   4   bit i=1: decimal point lit in digit i's slot
//  anode      out  4   active-low digit enables, one-hot-low; bit i = digit i
//  seg        out  7   active-low segments {g,f,e,d,c,b,a}
//  dp         out  1   active-low decimal point
// BEHAVIOUR
//  - State: refresh_cnt (0..REFRESH_DIV-1), idx (2b, 0..3), blink_cnt (0..BLINK_DIV-1),
//    blink_off (1b), snap (16b frame snapshot). All async-reset to 0.
//  - Outputs registered; async reset: anode=4'b1111, seg=7'b1111111, dp=1 (all dark).
//  - refresh_cnt increments each cycle; at REFRESH_DIV-1 it wraps to 0 and idx increments
//    (3 wraps to 0). Slot sequence 0,1,2,3,0,... each exactly REFRESH_DIV cycles.
//  - Snapshot: when refresh_cnt==REFRESH_DIV-1 and idx==3, snap<=digits. All four digits of
//    one frame come from the same snapshot (no tearing when counters roll mid-frame).
//  - Output latency: one cycle. Edge k registers outputs from idx/snap/blink_off held before
//    edge k. First slot after reset release: digit 0 of snap=0000 -> "0".
//  - anode = ~(4'b0001 << idx) always (anode stays driven even when digit blanked).
//  - Digit value v = snap[4*idx+3 : 4*idx]. Decode (seg, active low):
//    0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010
//    7=1111000 8=0000000 9=0010000; 10..15 = 0111111 (dash, segment g only).
//  - Blank (seg=1111111, dp=1) when (blink_en[idx] & blink_off) or
//    (idx==3 & lz_blank & v==0). Blank wins over dash and dp.
//  - dp = ~dp_mask[idx] unless blanked.
//  - blink_cnt counts every cycle; at BLINK_DIV-1 wraps and toggles blink_off. Free-running,
//    independent of blink_en; blink_en, lz_blank, dp_mask are sampled live (not snapshotted).
//  - Reset mid-frame: outputs dark immediately (async), restart at slot 0, blink_off=0.
//  - No handshake; digits may change any cycle, only frame-boundary value is displayed.
// TESTING  (bench params REFRESH_DIV=4, BLINK_DIV=16)
//  - Reset held -> anode=1111, seg=1111111, dp=1; release -> anode 1110 seg 1000000 after
//    first edge; anode steps 1110,1101,1011,0111 every 4 cycles, repeats.
//  - digits=16'h1259 stable 2 frames -> slots show 9,5,2,1: seg 0010000,0010010,
//    0100100,1111001.
//  - digits changes 16'h1259->16'h1300 mid-frame (idx=1) -> rest of frame still 1259;
//    next frame shows 0,0,3,1.
//  - digits=16'h0930, lz_blank=1 -> slot 3 seg=1111111; lz_blank=0 -> slot 3 seg=1000000;
//    digit nibble 4'hB -> seg=0111111.
//  - blink_en=4'b1100 -> slots 2,3 dark for 16 cycles, lit for 16, alternating; slots 0,1
//    never dark; anode still cycles normally.
//  - dp_mask=4'b0100 -> dp=0 only in slot 2; assert rst for 1 cycle mid-slot 2 -> outputs
//    dark at once, scan resumes at slot 0 with snap=0000.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Multiplexes the clock's packed BCD word {H10,H1,M10,M1} onto a common-anode
//   4-digit 7-segment display. It adds per-digit blink, blanking of a leading
//   zero in the hour-tens digit, and a per-digit decimal point.
//
//   Ports
//     clk       system clock, all logic on the rising edge
//     rst       asynchronous active-high reset (drives all outputs dark)
//     digits    BCD input: [3:0]=M1, [7:4]=M10, [11:8]=H1, [15:12]=H10
//     blink_en  bit i=1: digit i is dark during the blink-off phase
//     lz_blank  1: blank digit 3 when its value is 0
//     dp_mask   bit i=1: decimal point lit in digit i's slot
//     anode     active-low digit enables, one-hot-low, bit i = digit i
//     seg       active-low segments {g,f,e,d,c,b,a}
//     dp        active-low decimal point
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  blink_en,
  input  logic        lz_blank,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [6:0]    SEG_DARK   = 7'b1111111;

  // Active-low decode; non-BCD nibbles show a dash (segment g only).
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_off_q, blink_off_d;
  logic [15:0]   snap_q, snap_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          refresh_wrap;
  logic          blink_wrap;
  logic [3:0]    digit_val;
  logic          blank;

  always_comb begin
    refresh_wrap  = (refresh_cnt_q == REF_LAST);
    refresh_cnt_d = refresh_wrap ? '0 : refresh_cnt_q + RW'(1);
    idx_d         = refresh_wrap ? idx_q + 2'd1 : idx_q;
    // Capture a whole frame at once on the last cycle of slot 3 so the four
    // digits shown in one frame always come from the same input word.
    snap_d        = (refresh_wrap && (idx_q == 2'd3)) ? digits : snap_q;

    blink_wrap    = (blink_cnt_q == BLINK_LAST);
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BW'(1);
    blink_off_d   = blink_wrap ? ~blink_off_q : blink_off_q;

    digit_val     = snap_q[{idx_q, 2'b00} +: 4];
    blank         = (blink_en[idx_q] & blink_off_q) |
                    ((idx_q == 2'd3) & lz_blank & (digit_val == 4'd0));

    // Anode keeps scanning even when the digit itself is blanked.
    anode_d       = ~(4'b0001 << idx_q);
    seg_d         = blank ? SEG_DARK : bcd_to_seg(digit_val);
    dp_d          = blank | ~dp_mask[idx_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt_q <= '0;
      idx_q         <= 2'd0;
      blink_cnt_q   <= '0;
      blink_off_q   <= 1'b0;
      snap_q        <= 16'h0000;
      anode_q       <= 4'b1111;
      seg_q         <= SEG_DARK;
      dp_q          <= 1'b1;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_off_q   <= blink_off_d;
      snap_q        <= snap_d;
      anode_q       <= anode_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign anode = anode_q;
  assign seg   = seg_q;
  assign dp    = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;

  localparam int REFRESH_DIV = 4;
  localparam int BLINK_DIV   = 16;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SX = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  blink_en;
  logic        lz_blank;
  logic [3:0]  dp_mask;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;

  seven_seg_scanner #(
    .REFRESH_DIV(REFRESH_DIV),
    .BLINK_DIV  (BLINK_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .digits   (digits),
    .blink_en (blink_en),
    .lz_blank (lz_blank),
    .dp_mask  (dp_mask),
    .anode    (anode),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  // segs packs the expected segment pattern of slots {3,2,1,0}; dpx is the
  // expected active-low dp per slot.
  typedef struct packed {
    logic [15:0] digits;
    logic        lz;
    logic [3:0]  dpm;
    logic [27:0] segs;
    logic [3:0]  dpx;
  } vec_t;

  vec_t vecs [5];

  task automatic compare_now(input logic [3:0] ea, input logic [6:0] es,
                             input logic ed, input string nm);
    checks++;
    if (anode !== ea) begin
      errors++;
      $display("FAIL %s anode got %b expected %b", nm, anode, ea);
    end
    checks++;
    if (seg !== es) begin
      errors++;
      $display("FAIL %s seg got %b expected %b", nm, seg, es);
    end
    checks++;
    if (dp !== ed) begin
      errors++;
      $display("FAIL %s dp got %b expected %b", nm, dp, ed);
    end
  endtask

  task automatic step_check(input logic [3:0] ea, input logic [6:0] es,
                            input logic ed, input string nm);
    @(posedge clk);
    @(negedge clk);
    compare_now(ea, es, ed, nm);
  endtask

  task automatic slot_check(input int slot, input logic [6:0] es, input logic ed,
                            input int n, input string nm);
    logic [3:0] ea;
    ea = ~(4'b0001 << slot);
    for (int c = 0; c < n; c++) step_check(ea, es, ed, nm);
  endtask

  task automatic frame_check(input logic [27:0] segs, input logic [3:0] dpx,
                             input string nm);
    for (int s = 0; s < 4; s++)
      slot_check(s, segs[s*7 +: 7], dpx[s], REFRESH_DIV, nm);
  endtask

  task automatic skip_frame();
    for (int c = 0; c < 4 * REFRESH_DIV; c++) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{digits: 16'h0930, lz: 1'b1, dpm: 4'b0000,
                segs: {SX, S9, S3, S0}, dpx: 4'b1111};
    vecs[1] = '{digits: 16'h0930, lz: 1'b0, dpm: 4'b0000,
                segs: {S0, S9, S3, S0}, dpx: 4'b1111};
    vecs[2] = '{digits: 16'hB7B6, lz: 1'b1, dpm: 4'b0000,
                segs: {SD, S7, SD, S6}, dpx: 4'b1111};
    vecs[3] = '{digits: 16'h8F4A, lz: 1'b0, dpm: 4'b0100,
                segs: {S8, SD, S4, SD}, dpx: 4'b1011};
    vecs[4] = '{digits: 16'h0000, lz: 1'b1, dpm: 4'b1000,
                segs: {SX, S0, S0, S0}, dpx: 4'b1111};

    rst      = 1'b1;
    digits   = 16'h1259;
    blink_en = 4'b0000;
    lz_blank = 1'b0;
    dp_mask  = 4'b0000;

    // Reset held: all dark.
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare_now(4'b1111, SX, 1'b1, "reset_held");
    rst = 1'b0;

    // Frame 0: snapshot still zero, anode walks 1110,1101,1011,0111.
    frame_check({S0, S0, S0, S0}, 4'b1111, "first_frame");
    // Frame 1: 1259 captured at end of frame 0.
    frame_check({S1, S2, S5, S9}, 4'b1111, "frame_1259_a");

    // Frame 2: change input in the middle of slot 1; frame must not tear.
    slot_check(0, S9, 1'b1, 4, "tear_slot0");
    slot_check(1, S5, 1'b1, 2, "tear_slot1a");
    digits = 16'h1300;
    slot_check(1, S5, 1'b1, 2, "tear_slot1b");
    slot_check(2, S2, 1'b1, 4, "tear_slot2");
    slot_check(3, S1, 1'b1, 4, "tear_slot3");
    // Frame 3: new word appears.
    frame_check({S1, S3, S0, S0}, 4'b1111, "frame_1300");

    // Frames 4..13: table vectors, one load frame then one checked frame.
    for (int i = 0; i < 5; i++) begin
      digits   = vecs[i].digits;
      lz_blank = vecs[i].lz;
      dp_mask  = vecs[i].dpm;
      skip_frame();
      frame_check(vecs[i].segs, vecs[i].dpx, $sformatf("vec%0d", i));
    end

    // Frames 14..17: blink on digits 2,3; odd frames are the blink-off phase.
    digits   = 16'h1259;
    lz_blank = 1'b0;
    dp_mask  = 4'b0000;
    blink_en = 4'b1100;
    frame_check({S0, S0, S0, S0}, 4'b1111, "blink_lit_a");
    frame_check({SX, SX, S5, S9}, 4'b1111, "blink_dark_a");
    frame_check({S1, S2, S5, S9}, 4'b1111, "blink_lit_b");
    frame_check({SX, SX, S5, S9}, 4'b1111, "blink_dark_b");

    // Frame 18: decimal point only in slot 2.
    blink_en = 4'b0000;
    dp_mask  = 4'b0100;
    frame_check({S1, S2, S5, S9}, 4'b1011, "dp_slot2");

    // Frame 19: reset in the middle of slot 2.
    slot_check(0, S9, 1'b1, 4, "pre_rst_slot0");
    slot_check(1, S5, 1'b1, 4, "pre_rst_slot1");
    slot_check(2, S2, 1'b0, 2, "pre_rst_slot2");
    rst = 1'b1;
    #1;
    compare_now(4'b1111, SX, 1'b1, "rst_async");
    blink_en = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    compare_now(4'b1111, SX, 1'b1, "rst_held_mid");
    rst = 1'b0;

    // After reset: slot 0 first, snapshot zero, blink phase restarted lit.
    frame_check({S0, S0, S0, S0}, 4'b1011, "post_rst_lit");
    frame_check({SX, SX, SX, SX}, 4'b1111, "post_rst_dark");
    blink_en = 4'b0000;
    frame_check({S1, S2, S5, S9}, 4'b1011, "post_rst_1259");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
